load_scoreboard_hazard: RTL and testbench
=========================================

Name: load_scoreboard_hazard

Overview:
- Stall/interlock controller, the counterpart of the EX-stage forwarding unit.
- The forwarding unit resolves RAW hazards for results already in MEM/WB. This block detects the hazards forwarding cannot cover: variable-latency loads whose data has not returned.
- Tracks outstanding load destinations in a 16-entry pending scoreboard. Drives stall to PC/IF-ID and bubble to ID/EX.
- Sits beside the ID stage; fed by decode and by the memory load-completion port.

Parameters:
- NREG, 16, number of architectural registers (address width 4).
- MAX_OUTSTANDING, 2, maximum in-flight loads (1..NREG-1).
- ZERO_REG_EN, 1, when 1 register 0 is never marked pending and never causes a stall.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  valid instruction in ID.
- id_src_a  in  4  source A register.
- id_use_a  in  1  instruction reads source A.
- id_src_b  in  4  source B register.
- id_use_b  in  1  instruction reads source B.
- id_regwrt  in  1  instruction writes a register.
- id_dest  in  4  destination register.
- id_is_load  in  1  instruction is a load.
- flush  in  1  branch/jump kill of the ID instruction this cycle.
- ld_done  in  1  load data returned and written back this cycle.
- ld_dest  in  4  destination of the completing load.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  insert NOP into ID/EX.
- issue  out  1  ID instruction advances to EX this cycle.
- pending  out  16  scoreboard bit vector (bit r = register r awaiting load).
- outstanding  out  2  in-flight load count (width clog2(MAX_OUTSTANDING+1)).
- sb_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0): pending=0, outstanding=0, sb_err=0. Combinational outputs then follow from the zero state (stall=0 when nothing pending).
- Hazard terms, all combinational from current state and ID inputs, gated by id_valid & ~flush:
  - raw_a = id_use_a & pending[id_src_a].
  - raw_b = id_use_b & pending[id_src_b].
  - waw = id_regwrt & pending[id_dest].
  - cap = id_is_load & (outstanding == MAX_OUTSTANDING).
- stall = raw_a | raw_b | waw | cap.
- bubble = stall | (flush & id_valid).
- issue = id_valid & ~flush & ~stall.
- No same-cycle bypass from ld_done. A stall on register X releases the cycle after ld_done for X, once the pending bit has cleared at the edge. The WB forwarding path supplies the data from then on.
- Sequential update, per rising edge:
  - If issue & id_is_load & id_regwrt, and not (ZERO_REG_EN & id_dest==0): set pending[id_dest] and count +1.
  - If ld_done and pending[ld_dest]: clear pending[ld_dest] and count -1.
  - If ld_done and not pending[ld_dest]: set sb_err; no state change.
  - Set and clear on different registers in the same cycle: both applied; count net unchanged.
  - Set and clear on the same register cannot occur because waw stalls the issue. If forced, clear wins and sb_err is set.
- A load to register 0 with ZERO_REG_EN=1 does not count toward outstanding.
- outstanding never exceeds MAX_OUTSTANDING and never underflows. An underflow attempt sets sb_err.
- flush does not touch the scoreboard: loads already issued still complete.
- sb_err clears only on reset.
- Reset mid-operation clears all tracking. Any ld_done arriving later for a pre-reset load sets sb_err; the memory side is reset together with this block.

Decomposition:
- Shared pipeline package: register-address width (4), NREG, and the NOP encoding used for bubble insertion.
- One natural sub-module, scoreboard_bits: a 16-bit set/clear register with read ports a, b, d and the error detect.
- Stall logic and the counter stay in the top module.

Test Plan:
- Load r3 issues; next cycle an add reads r3 (use_a=1) -> stall=1, bubble=1, issue=0 each cycle until ld_done with ld_dest=3; stall=0 the cycle after.
- Loads to r1 and r2 issue (outstanding=2); a third load to r4 -> stall from cap. ld_done for r1 -> outstanding=1 and the r4 load issues the following cycle.
- In one cycle, a load to r5 issues while ld_done for r1 arrives -> pending[5]=1, pending[1]=0, outstanding unchanged.
- Instruction writes r2 while r2 is pending (regwrt=1, not a load) -> waw stall until r2 completes. Same instruction with flush=1 -> stall=0, bubble=1, no state change.
- Load to r0 with ZERO_REG_EN=1 -> pending stays 0x0000, outstanding 0. ld_done with ld_dest=7 while pending[7]=0 -> sb_err=1 and held until reset.
- Assert rst_n=0 asynchronously mid-stall with pending=0x0018 -> pending=0, outstanding=0, stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/load_scoreboard_hazard_pkg.sv
// Shared pipeline definitions for the load scoreboard / interlock logic.
package load_scoreboard_hazard_pkg;

  // Architectural register file geometry.
  localparam int REG_AW = 4;
  localparam int NREG   = 16;

  // Encoding the ID/EX register loads when bubble is asserted (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Width needed to hold a count from 0 up to max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/load_scoreboard_hazard_if.sv
// Decode / load-completion / interlock signal bundle.
interface load_scoreboard_hazard_if #(
  parameter int CNT_W = 2
);
  import load_scoreboard_hazard_pkg::*;

  // Decode side
  logic            id_valid;
  reg_addr_t       id_src_a;
  logic            id_use_a;
  reg_addr_t       id_src_b;
  logic            id_use_b;
  logic            id_regwrt;
  reg_addr_t       id_dest;
  logic            id_is_load;
  logic            flush;
  // Memory load-completion port
  logic            ld_done;
  reg_addr_t       ld_dest;
  // Interlock results
  logic            stall;
  logic            bubble;
  logic            issue;
  logic [NREG-1:0] pending;
  logic [CNT_W-1:0] outstanding;
  logic            sb_err;

  modport master (
    output id_valid, id_src_a, id_use_a, id_src_b, id_use_b,
           id_regwrt, id_dest, id_is_load, flush, ld_done, ld_dest,
    input  stall, bubble, issue, pending, outstanding, sb_err
  );

  modport slave (
    input  id_valid, id_src_a, id_use_a, id_src_b, id_use_b,
           id_regwrt, id_dest, id_is_load, flush, ld_done, ld_dest,
    output stall, bubble, issue, pending, outstanding, sb_err
  );

endinterface

// File: rtl/load_scoreboard_hazard_sb.sv
// Pending-load bit vector: one set port, one clear port, three read ports,
// and detection of clears that do not match an outstanding load.
module scoreboard_bits
  import load_scoreboard_hazard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_set_en,
  input  reg_addr_t       i_set_addr,
  input  logic            i_clr_en,
  input  reg_addr_t       i_clr_addr,
  input  reg_addr_t       i_rd_a_addr,
  input  reg_addr_t       i_rd_b_addr,
  input  reg_addr_t       i_rd_d_addr,
  output logic [NREG-1:0] o_pending,
  output logic            o_rd_a,
  output logic            o_rd_b,
  output logic            o_rd_d,
  output logic            o_set_done,
  output logic            o_clr_done,
  output logic            o_err
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_clr_hit;
  logic            w_collide;

  assign w_clr_hit = i_clr_en & r_pending[i_clr_addr];
  // Same-register set and clear: the clear wins and the set is dropped.
  assign w_collide = i_set_en & w_clr_hit & (i_set_addr == i_clr_addr);

  assign o_set_done = i_set_en & ~w_collide;
  assign o_clr_done = w_clr_hit;
  assign o_err      = (i_clr_en & ~r_pending[i_clr_addr]) | w_collide;

  assign o_rd_a    = r_pending[i_rd_a_addr];
  assign o_rd_b    = r_pending[i_rd_b_addr];
  assign o_rd_d    = r_pending[i_rd_d_addr];
  assign o_pending = r_pending;

  // Next pending vector: apply the accepted set, then the accepted clear.
  always_comb begin
    // NOTE: assign the default first so every path drives the signal; no latch is inferred.
    w_pending_nxt = r_pending;
    if (o_set_done) w_pending_nxt[i_set_addr] = 1'b1;
    if (o_clr_done) w_pending_nxt[i_clr_addr] = 1'b0;
  end

  // Pending register; reset drops all tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this is a small flop vector, not a RAM, so it takes the async reset like any other state.
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
      r_pending <= w_pending_nxt;
    end
  end

endmodule

// File: rtl/load_scoreboard_hazard.sv
// Load-use interlock: stalls ID on hazards the forwarding network cannot
// cover (operands or destinations of loads whose data has not returned).
module load_scoreboard_hazard
  import load_scoreboard_hazard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ZERO_REG_EN     = 1,
  parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input logic                     clk,
  input logic                     rst_n,
  load_scoreboard_hazard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_gate;
  logic             w_rd_a, w_rd_b, w_rd_d;
  logic             w_raw_a, w_raw_b, w_waw, w_cap;
  logic             w_stall, w_issue;
  logic             w_zero_dest;
  logic             w_set_req, w_set_done, w_clr_done, w_err;
  logic             w_underflow;
  logic [NREG-1:0]  w_pending;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_sb_err;

  // Hazards only matter for a live instruction that is not being killed.
  assign w_gate  = bus.id_valid & ~bus.flush;
  assign w_raw_a = w_gate & bus.id_use_a  & w_rd_a;
  assign w_raw_b = w_gate & bus.id_use_b  & w_rd_b;
  assign w_waw   = w_gate & bus.id_regwrt & w_rd_d;
  assign w_cap   = w_gate & bus.id_is_load & (r_outstanding == CNT_MAX);

  // No bypass from ld_done: the pending bit must clear at the edge first.
  assign w_stall = w_raw_a | w_raw_b | w_waw | w_cap;
  assign w_issue = w_gate & ~w_stall;

  assign w_zero_dest = (ZERO_REG_EN != 0) && (bus.id_dest == '0);
  assign w_set_req   = w_issue & bus.id_is_load & bus.id_regwrt & ~w_zero_dest;

  scoreboard_bits u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_en    (w_set_req),
    .i_set_addr  (bus.id_dest),
    .i_clr_en    (bus.ld_done),
    .i_clr_addr  (bus.ld_dest),
    .i_rd_a_addr (bus.id_src_a),
    .i_rd_b_addr (bus.id_src_b),
    .i_rd_d_addr (bus.id_dest),
    .o_pending   (w_pending),
    .o_rd_a      (w_rd_a),
    .o_rd_b      (w_rd_b),
    .o_rd_d      (w_rd_d),
    .o_set_done  (w_set_done),
    .o_clr_done  (w_clr_done),
    .o_err       (w_err)
  );

  // A lone clear with nothing counted means tracking has gone inconsistent.
  assign w_underflow = w_clr_done & ~w_set_done & (r_outstanding == '0);

  // In-flight load count: saturating up/down, unchanged when set and clear coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_set_done, w_clr_done})
        2'b10:   if (r_outstanding != CNT_MAX) r_outstanding <= r_outstanding + CNT_ONE;
        2'b01:   if (r_outstanding != '0)      r_outstanding <= r_outstanding - CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sb_err <= 1'b0;
    else        r_sb_err <= r_sb_err | w_err | w_underflow;
  end

  assign bus.stall       = w_stall;
  assign bus.bubble      = w_stall | (bus.flush & bus.id_valid);
  assign bus.issue       = w_issue;
  assign bus.pending     = w_pending;
  assign bus.outstanding = r_outstanding;
  assign bus.sb_err      = r_sb_err;

endmodule

// File: tb/tb_load_scoreboard_hazard.sv
// Bench for load_scoreboard_hazard: directed vector table, an async-reset
// sequence, then random traffic against a set-of-pending-registers model.
module tb_load_scoreboard_hazard;

  typedef struct {
    logic       valid;
    logic [3:0] src_a;
    logic       use_a;
    logic [3:0] src_b;
    logic       use_b;
    logic       regwrt;
    logic [3:0] dest;
    logic       is_load;
    logic       flush;
    logic       ld_done;
    logic [3:0] ld_dest;
    logic       e_stall;
    logic       e_bubble;
    logic       e_issue;
    logic [15:0] e_pend;
    logic [1:0] e_out;
    logic       e_err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  load_scoreboard_hazard_if bus ();

  load_scoreboard_hazard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v, input logic [3:0] sa, input logic ua, input logic [3:0] sb, input logic ub,
    input logic rw, input logic [3:0] d, input logic ld, input logic fl, input logic dn,
    input logic [3:0] dd, input logic es, input logic eb, input logic ei,
    input logic [15:0] ep, input logic [1:0] eo, input logic ee);
    vec_t r;
    r.valid = v;  r.src_a = sa; r.use_a = ua; r.src_b = sb; r.use_b = ub;
    r.regwrt = rw; r.dest = d;  r.is_load = ld; r.flush = fl;
    r.ld_done = dn; r.ld_dest = dd;
    r.e_stall = es; r.e_bubble = eb; r.e_issue = ei;
    r.e_pend = ep; r.e_out = eo; r.e_err = ee;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_valid   = v.valid;
    bus.id_src_a   = v.src_a;
    bus.id_use_a   = v.use_a;
    bus.id_src_b   = v.src_b;
    bus.id_use_b   = v.use_b;
    bus.id_regwrt  = v.regwrt;
    bus.id_dest    = v.dest;
    bus.id_is_load = v.is_load;
    bus.flush      = v.flush;
    bus.ld_done    = v.ld_done;
    bus.ld_dest    = v.ld_dest;
  endtask

  // Called just after a falling edge: drive, check combinational outputs,
  // cross one rising edge, check state, return on the next falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    #1;
    check({tag, ".stall_bubble_issue"}, {bus.stall, bus.bubble, bus.issue},
          {v.e_stall, v.e_bubble, v.e_issue});
    @(posedge clk);
    #1;
    check({tag, ".pending"},     bus.pending,     v.e_pend);
    check({tag, ".outstanding"}, bus.outstanding, v.e_out);
    check({tag, ".sb_err"},      bus.sb_err,      v.e_err);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0,2'd0,0));
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];
  logic [15:0] m_pend;
  logic        m_err;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle();

    //      v sa ua sb ub rw d ld fl dn dd | st bu is pend      out err
    tbl.push_back(mk(1,0,0,0,0,1,3,1,0,0,0, 0,0,1,16'h0008,2'd1,0)); // load r3
    tbl.push_back(mk(1,3,1,0,0,1,6,0,0,0,0, 1,1,0,16'h0008,2'd1,0)); // add uses r3
    tbl.push_back(mk(1,3,1,0,0,1,6,0,0,1,3, 1,1,0,16'h0000,2'd0,0)); // ld_done r3, no bypass
    tbl.push_back(mk(1,3,1,0,0,1,6,0,0,0,0, 0,0,1,16'h0000,2'd0,0)); // released
    tbl.push_back(mk(1,0,0,0,0,1,1,1,0,0,0, 0,0,1,16'h0002,2'd1,0)); // load r1
    tbl.push_back(mk(1,0,0,0,0,1,2,1,0,0,0, 0,0,1,16'h0006,2'd2,0)); // load r2
    tbl.push_back(mk(1,0,0,0,0,1,4,1,0,0,0, 1,1,0,16'h0006,2'd2,0)); // load r4 cap
    tbl.push_back(mk(1,0,0,0,0,1,4,1,0,1,1, 1,1,0,16'h0004,2'd1,0)); // cap still, r1 done
    tbl.push_back(mk(1,0,0,0,0,1,4,1,0,0,0, 0,0,1,16'h0014,2'd2,0)); // load r4 issues
    tbl.push_back(mk(1,4,0,2,1,0,0,0,0,0,0, 1,1,0,16'h0014,2'd2,0)); // raw on b only
    tbl.push_back(mk(1,4,0,7,1,0,0,0,0,0,0, 0,0,1,16'h0014,2'd2,0)); // non-load at cap
    tbl.push_back(mk(0,4,1,0,0,1,4,1,0,0,0, 0,0,0,16'h0014,2'd2,0)); // invalid slot
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,4, 0,0,0,16'h0004,2'd1,0)); // r4 done
    tbl.push_back(mk(1,0,0,0,0,1,5,1,0,1,2, 0,0,1,16'h0020,2'd1,0)); // set r5 / clear r2
    tbl.push_back(mk(1,0,0,0,0,1,5,0,0,0,0, 1,1,0,16'h0020,2'd1,0)); // waw on r5
    tbl.push_back(mk(1,0,0,0,0,1,5,0,1,0,0, 0,1,0,16'h0020,2'd1,0)); // flushed
    tbl.push_back(mk(1,0,0,0,0,1,5,0,0,1,5, 1,1,0,16'h0000,2'd0,0)); // r5 done, still stalls
    tbl.push_back(mk(1,0,0,0,0,1,5,0,0,0,0, 0,0,1,16'h0000,2'd0,0)); // released
    tbl.push_back(mk(1,0,0,0,0,1,0,1,0,0,0, 0,0,1,16'h0000,2'd0,0)); // load r0 ignored
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,7, 0,0,0,16'h0000,2'd0,1)); // spurious done r7
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,2'd0,1)); // error sticks

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset.pending",     bus.pending,     16'h0);
    check("reset.outstanding", bus.outstanding, 2'd0);
    check("reset.sb_err",      bus.sb_err,      1'b0);
    check("reset.stall_bubble_issue", {bus.stall, bus.bubble, bus.issue}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Asynchronous reset in the middle of a stall with r3 and r4 pending.
    do_reset();
    run_vec(mk(1,0,0,0,0,1,3,1,0,0,0, 0,0,1,16'h0008,2'd1,0), "ar.load3");
    run_vec(mk(1,0,0,0,0,1,4,1,0,0,0, 0,0,1,16'h0018,2'd2,0), "ar.load4");
    drive(mk(1,3,1,0,0,1,6,0,0,0,0, 0,0,0,16'h0,2'd0,0));
    #1;
    check("ar.stall_before", bus.stall, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.pending",     bus.pending,     16'h0);
    check("ar.outstanding", bus.outstanding, 2'd0);
    check("ar.stall",       bus.stall,       1'b0);
    check("ar.sb_err",      bus.sb_err,      1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Completion for a load issued before reset is a protocol error.
    run_vec(mk(0,0,0,0,0,0,0,0,0,1,3, 0,0,0,16'h0000,2'd0,1), "ar.stale_done");

    // Random traffic against a model holding the set of pending registers.
    do_reset();
    m_pend = '0;
    m_err  = 1'b0;
    for (int n = 0; n < 800; n++) begin
      vec_t v;
      logic g, set_ok, clr_ok;
      int cnt;
      v.valid   = ($urandom_range(0, 9) < 8);
      v.src_a   = 4'($urandom_range(0, 5));
      v.use_a   = $urandom_range(0, 1) == 1;
      v.src_b   = 4'($urandom_range(0, 5));
      v.use_b   = $urandom_range(0, 1) == 1;
      v.dest    = 4'($urandom_range(0, 5));
      v.is_load = ($urandom_range(0, 9) < 4);
      v.regwrt  = v.is_load ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 1) == 1);
      v.flush   = ($urandom_range(0, 9) == 0);
      v.ld_done = 1'b0;
      v.ld_dest = 4'($urandom_range(0, 15));
      if (m_pend != 0 && $urandom_range(0, 9) < 4) begin
        v.ld_done = 1'b1;
        do v.ld_dest = 4'($urandom_range(0, 15)); while (!m_pend[v.ld_dest]);
      end else if ($urandom_range(0, 199) == 0) begin
        v.ld_done = 1'b1;
      end

      cnt = $countones(m_pend);
      g = v.valid && !v.flush;
      v.e_stall  = g && ((v.use_a && m_pend[v.src_a]) || (v.use_b && m_pend[v.src_b]) ||
                         (v.regwrt && m_pend[v.dest]) || (v.is_load && cnt == 2));
      v.e_bubble = v.e_stall || (v.flush && v.valid);
      v.e_issue  = g && !v.e_stall;

      set_ok = v.e_issue && v.is_load && v.regwrt && (v.dest != 0);
      clr_ok = v.ld_done && m_pend[v.ld_dest];
      if (v.ld_done && !m_pend[v.ld_dest]) m_err = 1'b1;
      if (set_ok && clr_ok && v.dest == v.ld_dest) begin
        set_ok = 1'b0;
        m_err  = 1'b1;
      end
      if (set_ok) m_pend[v.dest]    = 1'b1;
      if (clr_ok) m_pend[v.ld_dest] = 1'b0;

      v.e_pend = m_pend;
      v.e_out  = 2'($countones(m_pend));
      v.e_err  = m_err;
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
